// File: rtl/tc_pkg.sv
// Shared definitions for the operand-fetch block: FSM state encoding and
// default geometry of the banked operand SRAM.
package tc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   localparam int unsigned NumBanksDef     = 4;
   localparam int unsigned WordsPerBankDef = 256;
   localparam int unsigned DataWidthDef    = 32;

endpackage

// File: rtl/tc_operand_fetch_if.sv
// Bundles the command, SRAM read and operand-stream signals of tc_operand_fetch.
// Handshakes (req_*, op_*): a transfer happens on a rising edge where valid and
// ready are both high; once raised, valid and its payload hold until that edge.
interface tc_operand_fetch_if
   import tc_pkg::*;
#(
   parameter int unsigned NumBanks     = NumBanksDef,
   parameter int unsigned WordsPerBank = WordsPerBankDef,
   parameter int unsigned DataWidth    = DataWidthDef,
   parameter int unsigned AddrWidth    = $clog2(WordsPerBank)
);

   logic                                 req_valid;
   logic                                 req_ready;
   logic [AddrWidth-1:0]                 req_base_a;
   logic [AddrWidth-1:0]                 req_base_b;
   logic [AddrWidth:0]                   req_len;

   logic [NumBanks-1:0]                  sram_re;
   logic [NumBanks-1:0][AddrWidth-1:0]   sram_raddr1;
   logic [NumBanks-1:0][AddrWidth-1:0]   sram_raddr2;
   logic [NumBanks-1:0][DataWidth-1:0]   sram_rdataA;
   logic [NumBanks-1:0][DataWidth-1:0]   sram_rdataB;

   logic                                 op_valid;
   logic                                 op_ready;
   logic [NumBanks-1:0][DataWidth-1:0]   op_a;
   logic [NumBanks-1:0][DataWidth-1:0]   op_b;
   logic                                 op_last;
   logic                                 done;

   fetch_state_e                         state_dbg;

   modport slave (
      input  req_valid, req_base_a, req_base_b, req_len,
      input  sram_rdataA, sram_rdataB, op_ready,
      output req_ready, sram_re, sram_raddr1, sram_raddr2,
      output op_valid, op_a, op_b, op_last, done, state_dbg
   );

   modport master (
      output req_valid, req_base_a, req_base_b, req_len,
      output sram_rdataA, sram_rdataB, op_ready,
      input  req_ready, sram_re, sram_raddr1, sram_raddr2,
      input  op_valid, op_a, op_b, op_last, done, state_dbg
   );

endinterface

// File: rtl/tc_fetch_fifo.sv
// Two-entry valid/ready FIFO with fall-through: when empty, incoming data is
// presented on the output in the same cycle it arrives.
module tc_fetch_fifo #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_valid_i,
   input  logic [Width-1:0] push_data_i,
   output logic             pop_valid_o,
   input  logic             pop_ready_i,
   output logic [Width-1:0] pop_data_o,
   output logic [1:0]       count_o
);

   logic [Width-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic [1:0]       count_d;
   logic             empty;
   logic             pop;
   logic             pop_stored;
   logic             store;

   assign empty       = (count_q == 2'd0);
   assign pop_valid_o = !empty || push_valid_i;
   assign pop_data_o  = empty ? push_data_i : mem_q[rd_ptr_q];
   assign pop         = pop_valid_o && pop_ready_i;
   assign pop_stored  = pop && !empty;
   // A word that bypasses straight to a taker never occupies an entry.
   assign store       = push_valid_i && !(empty && pop);
   assign count_d     = count_q + {1'b0, store} - {1'b0, pop_stored};
   assign count_o     = count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         count_q <= count_d;
         if (store)      wr_ptr_q <= !wr_ptr_q;
         if (pop_stored) rd_ptr_q <= !rd_ptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (store) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/tc_operand_fetch.sv
// Streams len rows of operands A and B out of a banked SRAM (1-cycle read
// latency), one full row per beat, with credit-limited issue into a 2-entry FIFO.
module tc_operand_fetch
   import tc_pkg::*;
#(
   parameter int unsigned NumBanks     = NumBanksDef,
   parameter int unsigned WordsPerBank = WordsPerBankDef,
   parameter int unsigned DataWidth    = DataWidthDef,
   parameter int unsigned AddrWidth    = $clog2(WordsPerBank)
) (
   input logic               clk,
   input logic               rst,
   tc_operand_fetch_if.slave bus
);

   localparam int unsigned          RowBits   = NumBanks * DataWidth;
   localparam int unsigned          BeatWidth = 2 * RowBits + 1;
   localparam logic [AddrWidth-1:0] LastRow   = AddrWidth'(WordsPerBank - 1);

   fetch_state_e          state_q;
   logic [AddrWidth-1:0]  row_a_q, row_a_d;
   logic [AddrWidth-1:0]  row_b_q, row_b_d;
   logic [AddrWidth:0]    remain_q;
   logic                  inflight_q;
   logic                  inflight_last_q;
   logic                  zero_done_q;

   logic                  issue;
   logic                  final_issue;
   logic                  pop;
   logic                  last_hs;
   logic                  pop_valid;
   logic [1:0]            fifo_count;
   logic [2:0]            occ_after;
   logic [BeatWidth-1:0]  push_data;
   logic [BeatWidth-1:0]  pop_data;

   assign row_a_d = (row_a_q == LastRow) ? '0 : row_a_q + AddrWidth'(1);
   assign row_b_d = (row_b_q == LastRow) ? '0 : row_b_q + AddrWidth'(1);

   // Credit counts the word in flight and FIFO contents left after this
   // cycle's pop, so a full-rate stream keeps issuing every cycle.
   assign pop         = pop_valid && bus.op_ready;
   assign occ_after   = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
   assign issue       = (state_q == ST_FETCH) && (occ_after < 3'd2);
   assign final_issue = issue && (remain_q == (AddrWidth + 1)'(1));
   assign last_hs     = pop && pop_data[0];

   always_comb begin
      bus.sram_re     = {NumBanks{issue}};
      bus.sram_raddr1 = '0;
      bus.sram_raddr2 = '0;
      for (int b = 0; b < NumBanks; b++) begin
         bus.sram_raddr1[b] = issue ? row_a_q : '0;
         bus.sram_raddr2[b] = issue ? row_b_q : '0;
      end
   end

   assign push_data = {bus.sram_rdataA, bus.sram_rdataB, inflight_last_q};

   tc_fetch_fifo #(.Width(BeatWidth)) u_fifo (
      .clk          (clk),
      .rst          (rst),
      .push_valid_i (inflight_q),
      .push_data_i  (push_data),
      .pop_valid_o  (pop_valid),
      .pop_ready_i  (bus.op_ready),
      .pop_data_o   (pop_data),
      .count_o      (fifo_count)
   );

   assign bus.op_valid  = pop_valid;
   assign bus.op_a      = pop_data[BeatWidth-1 -: RowBits];
   assign bus.op_b      = pop_data[RowBits:1];
   assign bus.op_last   = pop_data[0];
   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.state_dbg = state_q;
   // The final handshake itself signals completion; a zero-length command
   // only gets the registered pulse.
   assign bus.done      = last_hs || zero_done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         row_a_q         <= '0;
         row_b_q         <= '0;
         remain_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         zero_done_q     <= 1'b0;
      end else begin
         inflight_q      <= issue;
         inflight_last_q <= final_issue;
         zero_done_q     <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  if (bus.req_len == '0) begin
                     zero_done_q <= 1'b1;
                  end else begin
                     row_a_q  <= bus.req_base_a;
                     row_b_q  <= bus.req_base_b;
                     remain_q <= bus.req_len;
                     state_q  <= ST_FETCH;
                  end
               end
            end
            ST_FETCH: begin
               if (issue) begin
                  row_a_q  <= row_a_d;
                  row_b_q  <= row_b_d;
                  remain_q <= remain_q - (AddrWidth + 1)'(1);
                  if (final_issue) state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (last_hs) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
